sprite_motion_ctrl: RTL and testbench
=====================================

# sprite_motion_ctrl

Frame-synchronous controller that sequences the sprite-1 inputs of the VGA game display (`sp1_x`, `sp1_y`, `sp1_addr`, `sp1_en`) from the controller buttons. It sits between the button input and the display block. It edge-detects the display's end-of-frame pulse and computes one position/animation update per frame. Outputs are committed only inside vertical blanking, so the display never sees a half-updated sprite.

## Interface
- `SCREEN_W`, 160: logical screen width in 4×4 pixels
- `SCREEN_H`, 120: logical screen height
- `SPRITE_SIZE`, 16: sprite edge length
- `STEP`, 1: pixels moved per frame per axis
- `ANIM_FRAMES`, 4: number of animation cels
- `ANIM_DIV`, 8: moving frames per cel advance
- `FRAME_STRIDE`, 256: GRAM words per cel
- `clk`  in  1  system clock, 100 MHz; all logic on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `screenEnd`  in  1  end-of-frame pulse from the display timing, spanning ≥1 `clk` cycle
- `buttons`  in  8  raw controller buttons: [0]=up, [1]=down, [2]=left, [3]=right, [4]=A, [7:5] unused
- `enable`  in  1  when low, updates are skipped and outputs hold
- `sp1_x`  out  8  sprite left edge
- `sp1_y`  out  7  sprite top edge
- `sp1_addr`  out  32  sprite GRAM offset
- `sp1_en`  out  1  sprite visible
- `frame_tick`  out  1  one-cycle pulse on each commit
- `moving`  out  1  last commit applied nonzero motion

## Operation
- `buttons` pass through a 2-flop synchronizer. `screenEnd` is synchronized and rising-edge detected; a level held high yields exactly one update.
- FSM states:
  - IDLE: wait for a `screenEnd` rise. If `enable` is high, go to CALC; otherwise stay in IDLE.
  - CALC: latch the synced buttons and compute the next x, y, animation and visibility values into shadow registers.
  - COMMIT: copy the shadow registers to the outputs, pulse `frame_tick`, then return to IDLE.
- Motion, x axis:
  - dx = +STEP if right only, −STEP if left only.
  - dx = 0 if both or neither of left/right are pressed.
- Motion, y axis:
  - dy = +STEP if down only, −STEP if up only.
  - dy = 0 if both or neither of up/down are pressed.
- Clamping (default):
  - x is held in [0, SCREEN_W−SPRITE_SIZE] = [0,144].
  - y is held in [0, SCREEN_H−SPRITE_SIZE] = [0,104].
  - Arithmetic is done at 9/8 bits signed so it never underflows.
- `moving` = (new position ≠ old position). Pushing into a wall with no resulting change gives `moving` = 0.
- Animation:
  - While moving, a divider counter increments each commit. When it reaches ANIM_DIV−1 it wraps to 0 and the cel index advances mod ANIM_FRAMES.
  - When not moving, the divider and the cel index reset to 0.
  - `sp1_addr` = cel × FRAME_STRIDE, zero-extended to 32 bits.
- A button (bit 4): a press edge, compared against the value latched in the previous CALC, toggles `sp1_en`. Holding A toggles only once.

## Timing
- Reset values:
  - `sp1_x`=72, `sp1_y`=52, `sp1_addr`=0, `sp1_en`=1
  - `frame_tick`=0, `moving`=0
  - FSM=IDLE, divider=0, cel=0, previous-A=0
- Latency: outputs update exactly 5 `clk` cycles after the raw `screenEnd` rise. This is 2 cycles of sync, 1 of edge detect, 1 in CALC and 1 in COMMIT, well inside vertical blanking.
- `frame_tick` is high for exactly one cycle, coincident with the output update.
- Between commits the outputs are stable.
- An asynchronous `reset` asserted mid-CALC or mid-COMMIT aborts the update; all state returns to its reset value immediately.
- A `screenEnd` rise arriving while in CALC or COMMIT is ignored. This cannot occur at legal frame rates.

## Configuration
- `SPRITE_WRAP_EN`:
  - Defined: the position wraps instead of clamping.
    - Moving right from x=144 gives x=0; moving left from x=0 gives x=144.
    - Moving down from y=104 gives y=0; moving up from y=0 gives y=104.
    - `moving`=1 on a wrap.
  - Undefined: the clamping behaviour above applies.

## Test plan
- Reset, then release with no buttons and 3 frames → x=72, y=52, addr=0, en=1, `moving`=0 on every `frame_tick`.
- Hold right for 80 frames → x increases by 1 per frame and saturates at 144. Cel advances every 8 frames; addr sequence 0,256,512,768,0… while moving; `moving`=0 once pinned at 144.
- Hold left+up+down together for 5 frames → x decreases by 5, y unchanged at 52.
- Press A held across 4 frames → `sp1_en` goes 1→0 once. Release and press again → `sp1_en`=1.
- Hold `screenEnd` high for 400 cycles → exactly one `frame_tick` and one position step. With `enable`=0 → no `frame_tick` and outputs frozen.
- Assert `reset` 1 cycle after the edge-detect pulse → outputs are at reset values immediately and no `frame_tick`. With `SPRITE_WRAP_EN` defined, hold left from x=0 → x=144.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-synchronous sprite-1 position/animation sequencer.
// Buttons and the display's end-of-frame pulse are synchronized. One update is
// computed per frame and committed to the outputs inside vertical blanking.
// Optional feature macro: SPRITE_WRAP_EN (position wraps at the screen edges
// instead of clamping).
module sprite_motion_ctrl #(
   parameter int unsigned SCREEN_W     = 160,
   parameter int unsigned SCREEN_H     = 120,
   parameter int unsigned SPRITE_SIZE  = 16,
   parameter int unsigned STEP         = 1,
   parameter int unsigned ANIM_FRAMES  = 4,
   parameter int unsigned ANIM_DIV     = 8,
   parameter int unsigned FRAME_STRIDE = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        screenEnd,
   input  logic [7:0]  buttons,
   input  logic        enable,
   output logic [7:0]  sp1_x,
   output logic [6:0]  sp1_y,
   output logic [31:0] sp1_addr,
   output logic        sp1_en,
   output logic        frame_tick,
   output logic        moving
);

   localparam int unsigned X_MAX  = SCREEN_W - SPRITE_SIZE;
   localparam int unsigned Y_MAX  = SCREEN_H - SPRITE_SIZE;
   localparam int unsigned X_INIT = X_MAX / 2;
   localparam int unsigned Y_INIT = Y_MAX / 2;
   localparam int unsigned CEL_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam int unsigned DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   localparam logic signed [8:0] STEP_X = 9'(STEP);
   localparam logic signed [7:0] STEP_Y = 8'(STEP);
   localparam logic signed [8:0] X_LIM  = 9'(X_MAX);
   localparam logic signed [7:0] Y_LIM  = 8'(Y_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [4:0] btn_s1, btn_s2;
   logic       se_s1, se_s2, se_s3;
   logic       se_rise;
   logic       unused_btn;

   logic signed [8:0] dx, x_sum;
   logic signed [7:0] dy, y_sum;
   logic [7:0]        nx;
   logic [6:0]        ny;
   logic              mov_c;
   logic              en_c;
   logic [DIV_W-1:0]  div_d, div_q;
   logic [CEL_W-1:0]  cel_d, cel_q;

   logic [7:0] x_sh;
   logic [6:0] y_sh;
   logic       en_sh;
   logic       mov_sh;
   logic       prev_a_q;

   assign unused_btn = ^buttons[7:5];
   assign se_rise    = se_s2 & ~se_s3;

   // Two-flop synchronizers for buttons and screenEnd, plus delay for edge detect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         se_s1  <= 1'b0;
         se_s2  <= 1'b0;
         se_s3  <= 1'b0;
      end else begin
         btn_s1 <= buttons[4:0];
         btn_s2 <= btn_s1;
         se_s1  <= screenEnd;
         se_s2  <= se_s1;
         se_s3  <= se_s2;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: one CALC/COMMIT pass per enabled end-of-frame rise
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (se_rise && enable) state_d = CALC;
         CALC:    state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next position, animation and visibility from the synced buttons
   always_comb begin
      dx = '0;
      dy = '0;
      if (btn_s2[3] && !btn_s2[2])      dx = STEP_X;
      else if (btn_s2[2] && !btn_s2[3]) dx = -STEP_X;
      if (btn_s2[1] && !btn_s2[0])      dy = STEP_Y;
      else if (btn_s2[0] && !btn_s2[1]) dy = -STEP_Y;

      x_sum = $signed({1'b0, sp1_x}) + dx;
      y_sum = $signed({1'b0, sp1_y}) + dy;

`ifdef SPRITE_WRAP_EN
      if (x_sum[8])           nx = 8'(X_MAX);
      else if (x_sum > X_LIM) nx = 8'd0;
      else                    nx = x_sum[7:0];
      if (y_sum[7])           ny = 7'(Y_MAX);
      else if (y_sum > Y_LIM) ny = 7'd0;
      else                    ny = y_sum[6:0];
`else
      if (x_sum[8])           nx = 8'd0;
      else if (x_sum > X_LIM) nx = 8'(X_MAX);
      else                    nx = x_sum[7:0];
      if (y_sum[7])           ny = 7'd0;
      else if (y_sum > Y_LIM) ny = 7'(Y_MAX);
      else                    ny = y_sum[6:0];
`endif

      mov_c = (nx != sp1_x) || (ny != sp1_y);

      div_d = '0;
      cel_d = '0;
      if (mov_c) begin
         if (div_q == DIV_W'(ANIM_DIV - 1)) begin
            div_d = '0;
            cel_d = (cel_q == CEL_W'(ANIM_FRAMES - 1)) ? '0 : cel_q + CEL_W'(1);
         end else begin
            div_d = div_q + DIV_W'(1);
            cel_d = cel_q;
         end
      end

      en_c = sp1_en ^ (btn_s2[4] & ~prev_a_q);
   end

   // Shadow registers loaded in CALC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_sh     <= 8'(X_INIT);
         y_sh     <= 7'(Y_INIT);
         en_sh    <= 1'b1;
         mov_sh   <= 1'b0;
         div_q    <= '0;
         cel_q    <= '0;
         prev_a_q <= 1'b0;
      end else if (state_q == CALC) begin
         x_sh     <= nx;
         y_sh     <= ny;
         en_sh    <= en_c;
         mov_sh   <= mov_c;
         div_q    <= div_d;
         cel_q    <= cel_d;
         prev_a_q <= btn_s2[4];
      end
   end

   // Output commit in COMMIT, with a coincident one-cycle frame_tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp1_x      <= 8'(X_INIT);
         sp1_y      <= 7'(Y_INIT);
         sp1_addr   <= '0;
         sp1_en     <= 1'b1;
         moving     <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= (state_q == COMMIT);
         if (state_q == COMMIT) begin
            sp1_x    <= x_sh;
            sp1_y    <= y_sh;
            sp1_addr <= 32'(cel_q) * FRAME_STRIDE;
            sp1_en   <= en_sh;
            moving   <= mov_sh;
         end
      end
   end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: random and directed frames against a
// behavioural model. Honours SPRITE_WRAP_EN in the model when defined.
module tb_sprite_motion_ctrl;

   localparam int XMAX_M   = 144;
   localparam int YMAX_M   = 104;
   localparam int STEP_M   = 1;
   localparam int DIV_M    = 8;
   localparam int FR_M     = 4;
   localparam int STRIDE_M = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        screenEnd;
   logic [7:0]  buttons;
   logic        enable;
   logic [7:0]  sp1_x;
   logic [6:0]  sp1_y;
   logic [31:0] sp1_addr;
   logic        sp1_en;
   logic        frame_tick;
   logic        moving;

   int cmp_count  = 0;
   int fail_count = 0;

   int mx, my, mcel, mdiv;
   bit men, mprev_a, mmov;

   sprite_motion_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .screenEnd  (screenEnd),
      .buttons    (buttons),
      .enable     (enable),
      .sp1_x      (sp1_x),
      .sp1_y      (sp1_y),
      .sp1_addr   (sp1_addr),
      .sp1_en     (sp1_en),
      .frame_tick (frame_tick),
      .moving     (moving)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mx = 72; my = 52; mcel = 0; mdiv = 0;
      men = 1'b1; mprev_a = 1'b0; mmov = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b);
      int dx, dy, nx, ny;
      dx = 0; dy = 0;
      if (b[3] && !b[2]) dx = STEP_M;
      if (b[2] && !b[3]) dx = -STEP_M;
      if (b[1] && !b[0]) dy = STEP_M;
      if (b[0] && !b[1]) dy = -STEP_M;
      nx = mx + dx;
      ny = my + dy;
`ifdef SPRITE_WRAP_EN
      if (nx < 0) nx = XMAX_M; else if (nx > XMAX_M) nx = 0;
      if (ny < 0) ny = YMAX_M; else if (ny > YMAX_M) ny = 0;
`else
      if (nx < 0) nx = 0; else if (nx > XMAX_M) nx = XMAX_M;
      if (ny < 0) ny = 0; else if (ny > YMAX_M) ny = YMAX_M;
`endif
      mmov = (nx != mx) || (ny != my);
      mx = nx;
      my = ny;
      if (mmov) begin
         mdiv = mdiv + 1;
         if (mdiv == DIV_M) begin
            mdiv = 0;
            mcel = (mcel + 1) % FR_M;
         end
      end else begin
         mdiv = 0;
         mcel = 0;
      end
      if (b[4] && !mprev_a) men = !men;
      mprev_a = b[4];
   endtask

   function automatic logic [49:0] model_vec(input logic tick);
      return {8'(mx), 7'(my), 32'(mcel * STRIDE_M), men, mmov, tick};
   endfunction

   function automatic logic [49:0] dut_vec();
      return {sp1_x, sp1_y, sp1_addr, sp1_en, moving, frame_tick};
   endfunction

   task automatic apply_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      model_reset();
   endtask

   // Drives one frame; obs is sampled 5 cycles after the raw screenEnd rise
   task automatic run_frame(input logic [7:0] b, input logic en_in,
                            output logic [49:0] obs, output int ticks);
      buttons = b;
      enable  = en_in;
      ticks   = 0;
      repeat (3) @(posedge clk);
      #1 screenEnd = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (frame_tick) ticks++;
      end
      obs = dut_vec();
      screenEnd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (frame_tick) ticks++;
      end
   endtask

   task automatic test_reset();
      cmp_count++;
      if (dut_vec() !== {8'd72, 7'd52, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         fail_count++;
         $display("FAIL reset_held: got %h expected %h", dut_vec(),
                  {8'd72, 7'd52, 32'd0, 1'b1, 1'b0, 1'b0});
      end
      @(posedge clk); #1 reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk); #1;
      cmp_count++;
      if (dut_vec() !== model_vec(1'b0)) begin
         fail_count++;
         $display("FAIL reset_released: got %h expected %h", dut_vec(), model_vec(1'b0));
      end
   endtask

   task automatic test_idle_frames();
      logic [49:0] obs;
      int ticks;
      for (int f = 0; f < 3; f++) begin
         run_frame(8'h00, 1'b1, obs, ticks);
         model_frame(8'h00);
         cmp_count++;
         if (obs !== model_vec(1'b1) || ticks != 1) begin
            fail_count++;
            $display("FAIL idle_frame %0d: got %h ticks %0d expected %h ticks 1",
                     f, obs, ticks, model_vec(1'b1));
         end
      end
   endtask

   task automatic test_hold_right();
      logic [49:0] obs;
      int ticks;
      apply_reset();
      for (int f = 0; f < 80; f++) begin
         run_frame(8'h08, 1'b1, obs, ticks);
         model_frame(8'h08);
         cmp_count++;
         if (obs !== model_vec(1'b1) || ticks != 1) begin
            fail_count++;
            $display("FAIL hold_right frame %0d: got %h ticks %0d expected %h ticks 1",
                     f, obs, ticks, model_vec(1'b1));
         end
      end
      cmp_count++;
      if (sp1_x !== 8'd144 || moving !== 1'b0) begin
         fail_count++;
         $display("FAIL right_pinned: got x=%0d moving=%b expected x=144 moving=0", sp1_x, moving);
      end
   endtask

   task automatic test_diag();
      logic [49:0] obs;
      int ticks;
      logic [7:0] x0;
      logic [6:0] y0;
      x0 = sp1_x;
      y0 = sp1_y;
      for (int f = 0; f < 5; f++) begin
         run_frame(8'h07, 1'b1, obs, ticks);
         model_frame(8'h07);
         cmp_count++;
         if (obs !== model_vec(1'b1) || ticks != 1) begin
            fail_count++;
            $display("FAIL left_up_down frame %0d: got %h ticks %0d expected %h ticks 1",
                     f, obs, ticks, model_vec(1'b1));
         end
      end
      cmp_count++;
      if (sp1_x !== x0 - 8'd5 || sp1_y !== y0) begin
         fail_count++;
         $display("FAIL left_up_down_total: got x=%0d y=%0d expected x=%0d y=%0d",
                  sp1_x, sp1_y, x0 - 8'd5, y0);
      end
   endtask

   task automatic test_a_toggle();
      logic [49:0] obs;
      int ticks;
      logic [7:0] seq [8] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h10, 8'h10};
      for (int f = 0; f < 8; f++) begin
         run_frame(seq[f], 1'b1, obs, ticks);
         model_frame(seq[f]);
         cmp_count++;
         if (obs !== model_vec(1'b1) || ticks != 1) begin
            fail_count++;
            $display("FAIL a_toggle frame %0d: got %h ticks %0d expected %h ticks 1",
                     f, obs, ticks, model_vec(1'b1));
         end
      end
   endtask

   task automatic test_screen_hold();
      logic [49:0] obs;
      int ticks;
      buttons = 8'h02;
      enable  = 1'b1;
      ticks   = 0;
      obs     = '0;
      repeat (3) @(posedge clk);
      #1 screenEnd = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (frame_tick) ticks++;
         if (i == 4) obs = dut_vec();
      end
      screenEnd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (frame_tick) ticks++;
      end
      model_frame(8'h02);
      cmp_count++;
      if (ticks != 1) begin
         fail_count++;
         $display("FAIL screen_hold_ticks: got %0d expected 1", ticks);
      end
      cmp_count++;
      if (obs !== model_vec(1'b1)) begin
         fail_count++;
         $display("FAIL screen_hold_out: got %h expected %h", obs, model_vec(1'b1));
      end
   endtask

   task automatic test_enable_low();
      logic [49:0] obs;
      int ticks;
      for (int f = 0; f < 3; f++) begin
         run_frame(8'h15, 1'b0, obs, ticks);
         cmp_count++;
         if (obs !== model_vec(1'b0) || ticks != 0) begin
            fail_count++;
            $display("FAIL enable_low frame %0d: got %h ticks %0d expected %h ticks 0",
                     f, obs, ticks, model_vec(1'b0));
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [49:0] obs;
      int ticks;
      for (int v = 0; v < 2; v++) begin
         for (int f = 0; f < 3; f++) begin
            run_frame(8'h0A, 1'b1, obs, ticks);
            model_frame(8'h0A);
         end
         buttons = 8'h0A;
         repeat (3) @(posedge clk);
         #1 screenEnd = 1'b1;
         repeat (3 + v) @(posedge clk);
         #1 reset = 1'b1;
         #1;
         model_reset();
         cmp_count++;
         if (dut_vec() !== model_vec(1'b0)) begin
            fail_count++;
            $display("FAIL reset_abort_%0d: got %h expected %h", v, dut_vec(), model_vec(1'b0));
         end
         screenEnd = 1'b0;
         ticks = 0;
         repeat (2) begin
            @(posedge clk); #1;
            if (frame_tick) ticks++;
         end
         reset = 1'b0;
         repeat (8) begin
            @(posedge clk); #1;
            if (frame_tick) ticks++;
         end
         cmp_count++;
         if (ticks != 0 || dut_vec() !== model_vec(1'b0)) begin
            fail_count++;
            $display("FAIL reset_abort_after_%0d: got %h ticks %0d expected %h ticks 0",
                     v, dut_vec(), ticks, model_vec(1'b0));
         end
      end
   endtask

   task automatic test_random();
      logic [49:0] obs;
      int ticks;
      logic [7:0] b;
      logic en_in;
      for (int f = 0; f < 80; f++) begin
         b     = 8'($urandom);
         en_in = ($urandom_range(0, 4) != 0);
         run_frame(b, en_in, obs, ticks);
         if (en_in) model_frame(b);
         cmp_count++;
         if (obs !== model_vec(en_in) || ticks != (en_in ? 1 : 0)) begin
            fail_count++;
            $display("FAIL random frame %0d b=%h en=%b: got %h ticks %0d expected %h",
                     f, b, en_in, obs, ticks, model_vec(en_in));
         end
      end
   endtask

   task automatic test_boundaries();
      logic [49:0] obs;
      int ticks;
      logic [7:0] seq [3] = '{8'h04, 8'h01, 8'h02};
      int len [3] = '{80, 60, 60};
      apply_reset();
      for (int s = 0; s < 3; s++) begin
         for (int f = 0; f < len[s]; f++) begin
            run_frame(seq[s], 1'b1, obs, ticks);
            model_frame(seq[s]);
            cmp_count++;
            if (obs !== model_vec(1'b1) || ticks != 1) begin
               fail_count++;
               $display("FAIL boundary b=%h frame %0d: got %h ticks %0d expected %h",
                        seq[s], f, obs, ticks, model_vec(1'b1));
            end
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      screenEnd = 1'b0;
      buttons   = 8'h00;
      enable    = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_idle_frames();
      test_hold_right();
      test_diag();
      test_a_toggle();
      test_screen_hold();
      test_enable_low();
      test_reset_abort();
      test_random();
      test_boundaries();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule
